tt_um_serial_addsub: RTL and testbench



---
 rtl/tt_um_serial_addsub.sv | 122 ++++++++++++
 tb/tb_tt_um_serial_addsub.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/tt_um_serial_addsub.sv
// Bit-serial 4-bit add/subtract, LSB first, through a 1-bit full adder/subtractor.
// Latency: done rises 7 edges after start is first sampled high; starts during SHIFT are dropped.
module tt_um_serial_addsub (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    DONE    = 2'd2,
    ILLEGAL = 2'd3
  } state_t;

  state_t     r_state, w_next;
  logic       r_sync1, r_sync2, r_sync2_d;
  logic [3:0] r_a, r_b, r_acc, r_res;
  logic [1:0] r_cnt;
  logic       r_mode, r_bc, r_co, r_zero;

  logic       w_start, w_load, w_step, w_last;
  logic       w_a, w_b, w_sum, w_bc_nxt;
  logic [3:0] w_acc_nxt;
  logic       w_unused;

  assign w_unused = &{1'b0, uio_in[7:2]};

  // The edge detector keeps sampling while ena is low, so an edge seen then is consumed.
  assign w_start = r_sync2 & ~r_sync2_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_sync2_d <= 1'b0;
    end else begin
      r_sync1   <= uio_in[0];
      r_sync2   <= r_sync1;
      r_sync2_d <= r_sync2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_step = 1'b0;
    w_last = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (ena && w_start) begin
          w_next = SHIFT;
          w_load = 1'b1;
        end
      end
      SHIFT: begin
        if (ena) begin
          w_step = 1'b1;
          if (r_cnt == 2'd3) begin
            w_last = 1'b1;
            w_next = DONE;
          end
        end
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_a       = r_a[0];
  assign w_b       = r_b[0];
  assign w_sum     = w_a ^ w_b ^ r_bc;
  assign w_bc_nxt  = r_mode ? ((w_a & w_b) | ((w_a ^ w_b) & r_bc))
                            : ((~w_a & w_b) | (~(w_a ^ w_b) & r_bc));
  assign w_acc_nxt = {w_sum, r_acc[3:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a    <= 4'd0;
      r_b    <= 4'd0;
      r_acc  <= 4'd0;
      r_mode <= 1'b0;
      r_bc   <= 1'b0;
      r_cnt  <= 2'd0;
      r_res  <= 4'd0;
      r_co   <= 1'b0;
      r_zero <= 1'b0;
    end else if (w_load) begin
      r_a    <= ui_in[3:0];
      r_b    <= ui_in[7:4];
      r_mode <= uio_in[1];
      r_bc   <= 1'b0;
      r_cnt  <= 2'd0;
    end else if (w_step) begin
      r_a   <= {1'b0, r_a[3:1]};
      r_b   <= {1'b0, r_b[3:1]};
      r_acc <= w_acc_nxt;
      r_bc  <= w_bc_nxt;
      r_cnt <= r_cnt + 2'd1;
      // Visible result only changes on completion; it persists through later loads.
      if (w_last) begin
        r_res  <= w_acc_nxt;
        r_co   <= w_bc_nxt;
        r_zero <= (w_acc_nxt == 4'd0) && !w_bc_nxt;
      end
    end
  end

  assign uo_out  = {r_zero, (r_state == DONE), (r_state == SHIFT), r_co, r_res};
  assign uio_out = {r_state, r_cnt, 4'b0000};
  assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_um_serial_addsub.sv
// Directed vector table plus hand-written multi-cycle sequences for tt_um_serial_addsub.
module tb_tt_um_serial_addsub;

  logic       clk, rst_n, ena;
  logic [7:0] ui_in, uio_in;
  logic [7:0] uo_out, uio_out, uio_oe;

  int n_pass = 0;
  int n_tot  = 0;

  tt_um_serial_addsub dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       mode;
    logic [7:0] exp_uo;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%02h expected 0x%02h", nm, act, exp);
  endtask

  // One rising edge, then settle before sampling or driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle start pulse with latency checks around the 7-edge schedule.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic m,
                        input logic [7:0] exp, input string nm);
    ui_in  = {b, a};
    uio_in = {6'b0, m, 1'b1};
    tick();
    uio_in[0] = 1'b0;
    tick();
    chk({nm, "_busy_e2"}, {7'b0, uo_out[5]}, 8'h00);
    repeat (4) tick();
    chk({nm, "_busyhi_donelo_e6"}, {6'b0, uo_out[6:5]}, 8'h01);
    tick();
    chk({nm, "_uo_e7"}, uo_out, exp);
  endtask

  initial begin
    int busy_n;
    int done_n;

    vecs[0] = '{4'd9,  4'd3, 1'b0, 8'h46};
    vecs[1] = '{4'd3,  4'd9, 1'b0, 8'h5A};
    vecs[2] = '{4'd9,  4'd9, 1'b1, 8'h52};
    vecs[3] = '{4'd5,  4'd5, 1'b0, 8'hC0};
    vecs[4] = '{4'd15, 4'd1, 1'b1, 8'h50};
    vecs[5] = '{4'd0,  4'd0, 1'b1, 8'hC0};
    vecs[6] = '{4'd0,  4'd1, 1'b0, 8'h5F};
    vecs[7] = '{4'd7,  4'd8, 1'b1, 8'h4F};
    vecs[8] = '{4'd12, 4'd5, 1'b0, 8'h47};

    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    #12;
    chk("rst_uo", uo_out, 8'h00);
    chk("rst_uio_out", uio_out, 8'h00);
    chk("rst_uio_oe", uio_oe, 8'hF0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("idle_uo", uo_out, 8'h00);

    foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].mode, vecs[i].exp_uo, $sformatf("vec%0d", i));

    // Start held high for 20 cycles: one operation only.
    ui_in  = {4'd1, 4'd2};
    uio_in = 8'b0000_0011;
    busy_n = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (uo_out[5]) busy_n++;
    end
    chk("held_busy_cycles", 8'(busy_n), 8'd4);
    chk("held_uo", uo_out, 8'h43);
    uio_in = 8'b0000_0010;
    repeat (3) tick();
    chk("held_done_kept", uo_out, 8'h43);

    // Re-pulse and operand change during SHIFT must be ignored.
    ui_in  = {4'd2, 4'd6};
    uio_in = 8'b0000_0001;
    tick();
    uio_in[0] = 1'b0;
    repeat (3) tick();
    chk("mid_retain_prev", uo_out, 8'h23);
    chk("mid_state_cnt", uio_out, 8'h50);
    uio_in = 8'b0000_0011;
    ui_in  = 8'hFF;
    tick();
    uio_in[0] = 1'b0;
    repeat (2) tick();
    chk("repulse_uo_e7", uo_out, 8'h44);
    busy_n = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (uo_out[5]) busy_n++;
    end
    chk("repulse_not_queued", 8'(busy_n), 8'd0);
    chk("repulse_uo_hold", uo_out, 8'h44);

    // ena low mid-SHIFT freezes the FSM and counter.
    run_op(4'd3, 4'd9, 1'b0, 8'h5A, "pre_ena");
    ui_in  = {4'd5, 4'd12};
    uio_in = 8'b0000_0001;
    tick();
    uio_in[0] = 1'b0;
    repeat (3) tick();
    ena = 1'b0;
    repeat (3) tick();
    chk("ena_hold_uio", uio_out, 8'h50);
    chk("ena_hold_uo", uo_out, 8'h3A);
    ena = 1'b1;
    repeat (3) tick();
    chk("ena_resume_uo", uo_out, 8'h47);

    // A start edge while ena is low is discarded.
    ena    = 1'b0;
    ui_in  = {4'd1, 4'd1};
    uio_in = 8'b0000_0011;
    tick();
    uio_in[0] = 1'b0;
    repeat (5) tick();
    ena = 1'b1;
    busy_n = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (uo_out[5]) busy_n++;
    end
    chk("ena_edge_dropped", 8'(busy_n), 8'd0);
    chk("ena_edge_uo", uo_out, 8'h47);

    // Reset in the second SHIFT cycle aborts the operation.
    ui_in  = {4'd3, 4'd9};
    uio_in = 8'b0000_0001;
    tick();
    uio_in[0] = 1'b0;
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_uo", uo_out, 8'h00);
    chk("midrst_uio_out", uio_out, 8'h00);
    chk("midrst_uio_oe", uio_oe, 8'hF0);
    @(negedge clk);
    rst_n = 1'b1;
    done_n = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (uo_out[6]) done_n++;
    end
    chk("midrst_no_done", 8'(done_n), 8'd0);
    run_op(4'd7, 4'd2, 1'b0, 8'h45, "post_rst");

    // Bounded wait sanity: done must still be present.
    done_n = 0;
    for (int k = 0; k < 5 && done_n == 0; k++) begin
      tick();
      if (uo_out[6]) done_n = 1;
    end
    chk("final_done_bounded", 8'(done_n), 8'd1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
